// File: rtl/mem_pkg.sv
// Shared types and widths for the memory line port and its arbiter.
package mem_pkg;

   localparam int LINE_W = 128;
   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

   // Enum values double as bit positions in the rr_arb2 request vector
   typedef enum logic {ICACHE, DCACHE} req_id_t;

   typedef enum logic {READ, WRITE} mem_op_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and backing-memory line ports around mem_arbiter.
interface mem_arbiter_if;
   import mem_pkg::*;

   logic              in_ic_read_en;
   logic              in_ic_write_en;
   logic [ADDR_W-1:0] in_ic_addr;
   logic [LINE_W-1:0] in_ic_write_data;
   logic [LINE_W-1:0] out_ic_read_data;
   logic              out_ic_ready;

   logic              in_dc_read_en;
   logic              in_dc_write_en;
   logic [ADDR_W-1:0] in_dc_addr;
   logic [LINE_W-1:0] in_dc_write_data;
   logic [LINE_W-1:0] out_dc_read_data;
   logic              out_dc_ready;

   logic              out_mem_read_en;
   logic              out_mem_write_en;
   logic [ADDR_W-1:0] out_mem_addr;
   logic [LINE_W-1:0] out_mem_write_data;
   logic [LINE_W-1:0] in_mem_read_data;
   logic              in_mem_ready;

   logic              out_busy;

   // The arbiter is the slave; caches plus memory together form the master side
   modport slave (
      input  in_ic_read_en, in_ic_write_en, in_ic_addr, in_ic_write_data,
      output out_ic_read_data, out_ic_ready,
      input  in_dc_read_en, in_dc_write_en, in_dc_addr, in_dc_write_data,
      output out_dc_read_data, out_dc_ready,
      output out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data,
      input  in_mem_read_data, in_mem_ready,
      output out_busy
   );

   modport master (
      output in_ic_read_en, in_ic_write_en, in_ic_addr, in_ic_write_data,
      input  out_ic_read_data, out_ic_ready,
      output in_dc_read_en, in_dc_write_en, in_dc_addr, in_dc_write_data,
      input  out_dc_read_data, out_dc_ready,
      input  out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data,
      output in_mem_read_data, in_mem_ready,
      input  out_busy
   );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the side that did not win last time wins.
module rr_arb2
   import mem_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last_grant,
   output logic       valid,
   output req_id_t    grant
);

   always_comb begin
      valid = |req;
      grant = ICACHE;
      if (&req) begin
         grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
      end else if (req[DCACHE]) begin
         grant = DCACHE;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache line requests onto the single memory port, one transaction at a time.
module mem_arbiter
   import mem_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   arb_state_t        state;
   req_id_t           owner;
   req_id_t           last_grant;
   mem_op_t           op;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] ic_rdata_q;
   logic [LINE_W-1:0] dc_rdata_q;
   logic              ic_ready_q;
   logic              dc_ready_q;
   logic              busy_q;

   logic              ic_req;
   logic              dc_req;
   logic              pick_valid;
   req_id_t           pick;
   logic              pick_read;
   logic [ADDR_W-1:0] pick_addr;
   logic [LINE_W-1:0] pick_wdata;

   assign ic_req = bus.in_ic_read_en | bus.in_ic_write_en;
   assign dc_req = bus.in_dc_read_en | bus.in_dc_write_en;

   rr_arb2 u_rr_arb2 (
      .req        ({dc_req, ic_req}),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .grant      (pick)
   );

   // A requester raising both enables is served as a read
   always_comb begin
      pick_read  = bus.in_ic_read_en;
      pick_addr  = bus.in_ic_addr;
      pick_wdata = bus.in_ic_write_data;
      if (pick == DCACHE) begin
         pick_read  = bus.in_dc_read_en;
         pick_addr  = bus.in_dc_addr;
         pick_wdata = bus.in_dc_write_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= ICACHE;
         last_grant <= DCACHE;
         op         <= READ;
         addr_q     <= '0;
         wdata_q    <= '0;
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
         ic_ready_q <= 1'b0;
         dc_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         ic_ready_q <= 1'b0;
         dc_ready_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner      <= pick;
                  last_grant <= pick;
                  op         <= pick_read ? READ : WRITE;
                  addr_q     <= pick_addr;
                  wdata_q    <= pick_wdata;
                  busy_q     <= 1'b1;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (bus.in_mem_ready) begin
                  if (owner == ICACHE) begin
                     ic_ready_q <= 1'b1;
                     if (op == READ) ic_rdata_q <= bus.in_mem_read_data;
                  end else begin
                     dc_ready_q <= 1'b1;
                     if (op == READ) dc_rdata_q <= bus.in_mem_read_data;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Enables drop in the ready cycle so memory never sees a restart
   assign bus.out_mem_read_en    = (state == BUSY) && (op == READ)  && !bus.in_mem_ready;
   assign bus.out_mem_write_en   = (state == BUSY) && (op == WRITE) && !bus.in_mem_ready;
   assign bus.out_mem_addr       = addr_q;
   assign bus.out_mem_write_data = wdata_q;
   assign bus.out_ic_read_data   = ic_rdata_q;
   assign bus.out_ic_ready       = ic_ready_q;
   assign bus.out_dc_read_data   = dc_rdata_q;
   assign bus.out_dc_ready       = dc_ready_q;
   assign bus.out_busy           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against an 11-cycle-latency line memory model.
module tb_mem_arbiter;

   localparam logic [127:0] LINE_1000 = 128'h00000000_00000000_00009073_05000093;
   localparam logic [127:0] LINE_2000 = 128'h00000000_00000000_00000000_00502423;
   localparam logic [127:0] LINE_0080 = 128'hFFFFFF7F_00000083_00000082_00000081;
   localparam logic [127:0] WLINE     = 128'h0000000D_0000000C_0000000B_0000000A;

   logic clk;
   logic reset;
   int   checks = 0;
   int   passes = 0;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: responds 11 cycles after the first enable, using the address held at completion
   logic [127:0] mem_store [logic [27:0]];
   bit           mem_active;
   bit           mem_is_write;
   int           mem_cnt;

   function automatic logic [127:0] line_at(input logic [31:0] a);
      if (mem_store.exists(a[31:4])) return mem_store[a[31:4]];
      return {~a, a + 32'h3, a + 32'h2, a + 32'h1};
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         mem_active           = 1'b0;
         mem_cnt              = 0;
         bus.in_mem_ready     = 1'b0;
         bus.in_mem_read_data = '0;
      end else if (bus.in_mem_ready) begin
         bus.in_mem_ready = 1'b0;
         mem_active       = 1'b0;
      end else if (mem_active) begin
         mem_cnt++;
         if (mem_cnt == 11) begin
            bus.in_mem_ready = 1'b1;
            if (mem_is_write) mem_store[bus.out_mem_addr[31:4]] = bus.out_mem_write_data;
            else bus.in_mem_read_data = line_at(bus.out_mem_addr);
         end
      end else if (bus.out_mem_read_en || bus.out_mem_write_en) begin
         mem_active   = 1'b1;
         mem_cnt      = 0;
         mem_is_write = bus.out_mem_write_en;
      end
   end

   task automatic clear_requests;
      bus.in_ic_read_en    = 1'b0;
      bus.in_ic_write_en   = 1'b0;
      bus.in_ic_addr       = '0;
      bus.in_ic_write_data = '0;
      bus.in_dc_read_en    = 1'b0;
      bus.in_dc_write_en   = 1'b0;
      bus.in_dc_addr       = '0;
      bus.in_dc_write_data = '0;
   endtask

   task automatic apply_reset;
      reset = 1'b0;
      clear_requests();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // One request from a single cache; latency counted in cycles from the request cycle
   task automatic do_txn(input bit use_dc, input bit is_write, input logic [31:0] addr,
                         input logic [127:0] wdata, output int lat, output logic [127:0] rdata,
                         output int other_pulses);
      lat = -1;
      other_pulses = 0;
      rdata = '0;
      @(posedge clk); #1;
      if (use_dc) begin
         bus.in_dc_addr = addr; bus.in_dc_write_data = wdata;
         bus.in_dc_read_en = !is_write; bus.in_dc_write_en = is_write;
      end else begin
         bus.in_ic_addr = addr; bus.in_ic_write_data = wdata;
         bus.in_ic_read_en = !is_write; bus.in_ic_write_en = is_write;
      end
      for (int c = 1; c <= 60 && lat < 0; c++) begin
         @(posedge clk); #1;
         if (use_dc ? bus.out_ic_ready : bus.out_dc_ready) other_pulses++;
         if (use_dc ? bus.out_dc_ready : bus.out_ic_ready) begin
            lat = c;
            rdata = use_dc ? bus.out_dc_read_data : bus.out_ic_read_data;
            clear_requests();
         end
      end
      clear_requests();
   endtask

   task automatic run_pair(output int ic_lat, output int dc_lat,
                           output logic [127:0] ic_d, output logic [127:0] dc_d);
      ic_lat = -1; dc_lat = -1; ic_d = '0; dc_d = '0;
      @(posedge clk); #1;
      bus.in_ic_addr = 32'h1000; bus.in_ic_read_en = 1'b1;
      bus.in_dc_addr = 32'h2000; bus.in_dc_read_en = 1'b1;
      for (int c = 1; c <= 80 && (ic_lat < 0 || dc_lat < 0); c++) begin
         @(posedge clk); #1;
         if (bus.out_ic_ready && ic_lat < 0) begin
            ic_lat = c; ic_d = bus.out_ic_read_data; bus.in_ic_read_en = 1'b0;
         end
         if (bus.out_dc_ready && dc_lat < 0) begin
            dc_lat = c; dc_d = bus.out_dc_read_data; bus.in_dc_read_en = 1'b0;
         end
      end
      clear_requests();
   endtask

   task automatic test_reset;
      reset = 1'b0;
      clear_requests();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.out_ic_ready, bus.out_dc_ready} !== 2'b00)
         $display("[TB] FAIL reset_ready: got %b expected 00", {bus.out_ic_ready, bus.out_dc_ready});
      else passes++;
      checks++;
      if ({bus.out_ic_read_data, bus.out_dc_read_data} !== '0)
         $display("[TB] FAIL reset_rdata: got %h/%h expected 0", bus.out_ic_read_data, bus.out_dc_read_data);
      else passes++;
      checks++;
      if ({bus.out_mem_read_en, bus.out_mem_write_en} !== 2'b00)
         $display("[TB] FAIL reset_mem_en: got %b expected 00", {bus.out_mem_read_en, bus.out_mem_write_en});
      else passes++;
      checks++;
      if ({bus.out_mem_addr, bus.out_mem_write_data} !== '0)
         $display("[TB] FAIL reset_mem_bus: got %h/%h expected 0", bus.out_mem_addr, bus.out_mem_write_data);
      else passes++;
      checks++;
      if (bus.out_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.out_busy);
      else passes++;
      reset = 1'b1;
   endtask

   task automatic test_single_ic_read;
      int lat = -1;
      int pulses = 0;
      bit en_first = 1'b0;
      bit en_gated = 1'b0;
      bit dc_touched = 1'b0;
      @(posedge clk); #1;
      bus.in_ic_addr = 32'h1000; bus.in_ic_read_en = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 1) en_first = bus.out_mem_read_en;
         if (bus.out_ic_ready) begin
            pulses++;
            if (lat < 0) lat = c;
            bus.in_ic_read_en = 1'b0;
         end
         if (bus.out_dc_ready !== 1'b0 || bus.out_dc_read_data !== '0) dc_touched = 1'b1;
         if (c == 12) begin
            @(negedge clk); #1;
            en_gated = (bus.out_mem_read_en === 1'b0);
         end
      end
      checks++;
      if (en_first !== 1'b1) $display("[TB] FAIL single_en_t1: got %b expected 1", en_first);
      else passes++;
      checks++;
      if (en_gated !== 1'b1) $display("[TB] FAIL single_en_gated: enable still high in ready cycle");
      else passes++;
      checks++;
      if (lat !== 13) $display("[TB] FAIL single_latency: got %0d expected 13", lat);
      else passes++;
      checks++;
      if (pulses !== 1) $display("[TB] FAIL single_pulses: got %0d expected 1", pulses);
      else passes++;
      checks++;
      if (bus.out_ic_read_data[31:0] !== 32'h05000093)
         $display("[TB] FAIL single_word0: got %h expected 05000093", bus.out_ic_read_data[31:0]);
      else passes++;
      checks++;
      if (bus.out_ic_read_data[63:32] !== 32'h00009073)
         $display("[TB] FAIL single_word1: got %h expected 00009073", bus.out_ic_read_data[63:32]);
      else passes++;
      checks++;
      if (dc_touched !== 1'b0) $display("[TB] FAIL single_dc_quiet: got activity expected none");
      else passes++;
   endtask

   task automatic test_simultaneous;
      int ic_lat, dc_lat;
      logic [127:0] ic_d, dc_d;
      apply_reset();
      run_pair(ic_lat, dc_lat, ic_d, dc_d);
      checks++;
      if (ic_lat !== 13) $display("[TB] FAIL pair_ic_latency: got %0d expected 13", ic_lat);
      else passes++;
      checks++;
      if (dc_lat !== 27) $display("[TB] FAIL pair_dc_latency: got %0d expected 27", dc_lat);
      else passes++;
      checks++;
      if (dc_d[31:0] !== 32'h00502423) $display("[TB] FAIL pair_dc_data: got %h expected 00502423", dc_d[31:0]);
      else passes++;
      checks++;
      if (ic_d !== LINE_1000) $display("[TB] FAIL pair_ic_data: got %h expected %h", ic_d, LINE_1000);
      else passes++;
   endtask

   task automatic test_back_to_back;
      logic [5:0] order = '0;
      int n = 0;
      int last = -1;
      int low_run = 0;
      int max_low = 0;
      bit both = 1'b0;
      @(posedge clk); #1;
      bus.in_ic_addr = 32'h1000; bus.in_ic_read_en = 1'b1;
      bus.in_dc_addr = 32'h2000; bus.in_dc_read_en = 1'b1;
      for (int c = 1; c <= 200 && n < 6; c++) begin
         @(posedge clk); #1;
         if (bus.out_busy === 1'b0) low_run++;
         else low_run = 0;
         if (low_run > max_low) max_low = low_run;
         if (bus.out_ic_ready && bus.out_dc_ready) both = 1'b1;
         if (bus.out_ic_ready) begin order[n] = 1'b0; n++; end
         else if (bus.out_dc_ready) begin order[n] = 1'b1; n++; end
         if (n == 6) begin last = c; clear_requests(); end
      end
      clear_requests();
      checks++;
      if (order !== 6'b101010 || n !== 6)
         $display("[TB] FAIL b2b_order: got %b (%0d grants) expected 101010 (6 grants)", order, n);
      else passes++;
      checks++;
      if (last !== 83) $display("[TB] FAIL b2b_sixth_ready: got %0d expected 83", last);
      else passes++;
      checks++;
      if (max_low !== 1) $display("[TB] FAIL b2b_busy_gap: got %0d expected 1", max_low);
      else passes++;
      checks++;
      if (both !== 1'b0) $display("[TB] FAIL b2b_dual_ready: both ready pulses seen together");
      else passes++;
   endtask

   task automatic test_write_then_read;
      int lat, other;
      logic [127:0] d;
      do_txn(1'b1, 1'b1, 32'h40, WLINE, lat, d, other);
      checks++;
      if (lat !== 13) $display("[TB] FAIL write_latency: got %0d expected 13", lat);
      else passes++;
      checks++;
      if (other !== 0) $display("[TB] FAIL write_ic_quiet: got %0d ic pulses expected 0", other);
      else passes++;
      checks++;
      if (d !== LINE_2000) $display("[TB] FAIL write_keeps_rdata: got %h expected %h", d, LINE_2000);
      else passes++;
      do_txn(1'b1, 1'b0, 32'h40, '0, lat, d, other);
      checks++;
      if (d !== WLINE || lat !== 13)
         $display("[TB] FAIL readback: got %h at %0d expected %h at 13", d, lat, WLINE);
      else passes++;
   endtask

   task automatic test_addr_hold;
      int lat = -1;
      logic [31:0] held = '0;
      logic [127:0] d = '0;
      @(posedge clk); #1;
      bus.in_dc_addr = 32'h80; bus.in_dc_read_en = 1'b1;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         @(posedge clk); #1;
         if (c == 3) bus.in_dc_addr = 32'h3000;
         if (c == 5) held = bus.out_mem_addr;
         if (bus.out_dc_ready) begin lat = c; d = bus.out_dc_read_data; end
      end
      clear_requests();
      checks++;
      if (held !== 32'h80) $display("[TB] FAIL hold_addr: got %h expected 00000080", held);
      else passes++;
      checks++;
      if (d !== LINE_0080 || lat !== 13)
         $display("[TB] FAIL hold_data: got %h at %0d expected %h at 13", d, lat, LINE_0080);
      else passes++;
   endtask

   task automatic test_reset_mid_busy;
      int pulses = 0;
      int ic_lat, dc_lat;
      logic [127:0] ic_d, dc_d;
      @(posedge clk); #1;
      bus.in_ic_addr = 32'h1000; bus.in_ic_read_en = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (bus.out_ic_ready || bus.out_dc_ready) pulses++;
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.out_busy, bus.out_mem_read_en, bus.out_mem_write_en} !== 3'b000)
         $display("[TB] FAIL midrst_ctrl: got %b expected 000",
                  {bus.out_busy, bus.out_mem_read_en, bus.out_mem_write_en});
      else passes++;
      checks++;
      if ({bus.out_mem_addr, bus.out_ic_read_data, bus.out_dc_read_data} !== '0)
         $display("[TB] FAIL midrst_data: got %h/%h/%h expected 0",
                  bus.out_mem_addr, bus.out_ic_read_data, bus.out_dc_read_data);
      else passes++;
      clear_requests();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         if (bus.out_ic_ready || bus.out_dc_ready || bus.out_busy) pulses++;
      end
      checks++;
      if (pulses !== 0) $display("[TB] FAIL midrst_no_ready: got %0d events expected 0", pulses);
      else passes++;
      run_pair(ic_lat, dc_lat, ic_d, dc_d);
      checks++;
      if (ic_lat !== 13 || dc_lat !== 27)
         $display("[TB] FAIL midrst_tie: got ic %0d dc %0d expected ic 13 dc 27", ic_lat, dc_lat);
      else passes++;
      checks++;
      if (ic_d !== LINE_1000) $display("[TB] FAIL midrst_ic_data: got %h expected %h", ic_d, LINE_1000);
      else passes++;
   endtask

   // Preload two program lines, then run each scenario in order
   initial begin
      mem_store[28'h100] = LINE_1000;
      mem_store[28'h200] = LINE_2000;
      test_reset();
      test_single_ic_read();
      test_simultaneous();
      test_back_to_back();
      test_write_then_read();
      test_addr_hold();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 128-bit line port of the backing memory between the instruction-cache and data-cache refill/writeback paths. Sits between both caches and the memory, and serialises their requests with a two-way round-robin policy. It captures each granted request, holds the memory request stable until memory completes, and routes the single-cycle completion pulse and line data back to the owning requester. Exactly one memory transaction is outstanding at any time.

## Interface
- `LINE_W`, default 128: cache-line width in bits.
- `ADDR_W`, default 32: byte-address width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_ic_read_en`, `in_ic_write_en`  in  1 each  icache read or write request; held until `out_ic_ready`.
- `in_ic_addr`  in  ADDR_W  icache line address.
- `in_ic_write_data`  in  LINE_W  icache write line.
- `out_ic_read_data`  out  LINE_W  line returned to the icache.
- `out_ic_ready`  out  1  one-cycle completion pulse to the icache.
- `in_dc_read_en`, `in_dc_write_en`, `in_dc_addr`, `in_dc_write_data`, `out_dc_read_data`, `out_dc_ready`: same as the icache set, for the dcache.
- `out_mem_read_en`, `out_mem_write_en`  out  1 each  memory request enables.
- `out_mem_addr`  out  ADDR_W  memory address.
- `out_mem_write_data`  out  LINE_W  memory write line.
- `in_mem_read_data`  in  LINE_W  memory read line.
- `in_mem_ready`  in  1  one-cycle memory completion pulse.
- `out_busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: sample the requests. If any requester is active, latch the winner's id, op, addr and write_data into internal registers, then go to BUSY.
  - BUSY: drive memory from the latched registers. On `in_mem_ready` = 1, latch `in_mem_read_data` and go to RESP.
  - RESP: pulse the owner's ready for one cycle, then go to IDLE.
- Requester enables are ignored in the BUSY and RESP states.
- Memory enable gating: `out_mem_read_en` = (state==BUSY && op==READ && !in_mem_ready); `out_mem_write_en` is the same with op==WRITE. These are the only combinational outputs. The gating guarantees the memory returns to idle without a spurious restart.
- `out_mem_addr` and `out_mem_write_data` are driven from the latched registers. They are stable for the whole of BUSY even if the requester changes its inputs.
- Arbitration, one pending requester: it is granted.
- Arbitration, both pending: grant the requester that is not `last_grant`. `last_grant` updates on every grant and resets to DCACHE, so the icache wins the first tie.
- One requester asserting both read_en and write_en: treated as a read; the write is dropped.
- Response routing: only the owner's ready pulses. The owner's read_data register loads `in_mem_read_data` on reads and keeps its old value on writes. The non-owner's outputs do not change.
- Requester contract: deassert (or change) the enable in the cycle after the ready pulse. An enable still high in IDLE after RESP is treated as a new request.
- Reset values: state = IDLE; `last_grant` = DCACHE; all ready pulses 0; both read_data outputs 0; all memory outputs 0; `out_busy` = 0. Latched registers are cleared to 0.
- Reset asserted mid-transaction aborts it: no ready pulse is issued. The memory must be reset in the same cycle.

## Timing
- Request seen in IDLE at cycle t. State is BUSY at t+1, with the memory enable high from t+1.
- `in_mem_ready` at cycle m. Memory enable is low at m (gated). State is RESP at m+1 and the owner's ready = 1 at m+1. State is IDLE at m+2.
- Arbiter overhead: 2 cycles per transaction plus 1 IDLE sampling cycle.
- Back-to-back throughput: with memory latency L from the first enable cycle to ready, one transaction completes every L+3 cycles.
- With the current 10-count memory, L = 11. First enable at t+1, memory ready at t+12, requester ready at t+13, next grant sampled at t+14.

## Structure
- Shared `mem_pkg` holds:
  - `arb_state_t` {IDLE, BUSY, RESP};
  - `req_id_t` {ICACHE, DCACHE};
  - `mem_op_t` {READ, WRITE};
  - `LINE_W` and `ADDR_W` constants.
- Sub-module `rr_arb2`: combinational two-way round-robin pick from two request bits plus `last_grant`. It is reusable for other shared ports.

## Test plan
- Single icache read of addr 0x1000 (word 0x400) with no dcache activity:
  - `out_mem_read_en` goes high the cycle after the request.
  - `out_ic_ready` pulses once, 13 cycles after the request.
  - `out_ic_read_data[31:0]` = 0x05000093 and `[63:32]` = 0x00009073.
  - The dcache outputs stay at 0.
- Simultaneous icache read (0x1000) and dcache read (0x2000) out of reset:
  - The icache is served first. `out_ic_ready` comes at t+13 and `out_dc_ready` at t+27.
  - `out_dc_read_data[31:0]` = 0x00502423.
- Both requesters kept continuously active for 6 transactions: grants alternate I, D, I, D, I, D, and `out_busy` never drops for more than 1 cycle.
- Dcache write of 0xA..D at addr 0x40, followed by a dcache read of 0x40:
  - The read returns the written line.
  - No ready pulse appears on the icache during the write.
- The requester changes `in_dc_addr` during BUSY: `out_mem_addr` holds the latched value, and the returned data matches the original address.
- Reset asserted at cycle 5 of BUSY:
  - All outputs go to 0 immediately and no ready pulse is issued.
  - After reset is released, a fresh icache request completes normally with `last_grant` reset behaviour.
